// File: rtl/bridge_2_1_pkg.sv
// Shared constants for the 2-to-1 SRAM-like bridge: owner ids, default depth, size codes.
package bridge_pkg;

  localparam int DEPTH = 4;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/bridge_2_1_if.sv
// SRAM-like req/addr_ok/data_ok port; master drives the request, slave answers.
interface bridge_2_1_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;

  modport master (output req, wr, size, addr, wdata,
                  input  rdata, addr_ok, data_ok);
  modport slave  (input  req, wr, size, addr, wdata,
                  output rdata, addr_ok, data_ok);
endinterface

// File: rtl/bridge_2_1_owner_fifo.sv
// In-order record of which master owns each accepted-but-unanswered transaction.
module owner_fifo #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic head_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem_q;
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      // simultaneous push and pop leaves occupancy unchanged
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/bridge_2_1.sv
// Two-master to one-slave SRAM-like arbiter with in-order response routing.
// Optional BRIDGE_RR_EN selects round-robin on contention instead of m1 priority.
module bridge_2_1 #(
  parameter int DEPTH = bridge_pkg::DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  bridge_2_1_if.slave  m0,
  bridge_2_1_if.slave  m1,
  bridge_2_1_if.master s,
  output logic         resp_err
);
  import bridge_pkg::*;

  logic        lock_q, lock_d;
  logic        lock_own_q, lock_own_d;
  logic        resp_err_q, resp_err_d;
  logic        gnt_vld;
  logic        gnt_own;
  logic        sel_req;
  logic        sel_wr;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        s_req_w;
  logic        accept;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_head;

`ifdef BRIDGE_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant_q <= OWN_M0;
    else if (accept) last_grant_q <= gnt_own;
  end
`endif

  always_comb begin
    gnt_vld = 1'b0;
    gnt_own = OWN_M0;
    if (lock_q) begin
      gnt_vld = 1'b1;
      gnt_own = lock_own_q;
    end else if (m0.req & m1.req) begin
      gnt_vld = 1'b1;
`ifdef BRIDGE_RR_EN
      gnt_own = ~last_grant_q;
`else
      gnt_own = OWN_M1;
`endif
    end else if (m1.req) begin
      gnt_vld = 1'b1;
      gnt_own = OWN_M1;
    end else if (m0.req) begin
      gnt_vld = 1'b1;
      gnt_own = OWN_M0;
    end
  end

  always_comb begin
    sel_req   = 1'b0;
    sel_wr    = 1'b0;
    sel_size  = 2'b00;
    sel_addr  = '0;
    sel_wdata = '0;
    if (gnt_vld) begin
      if (gnt_own == OWN_M1) begin
        sel_req   = m1.req;
        sel_wr    = m1.wr;
        sel_size  = m1.size;
        sel_addr  = m1.addr;
        sel_wdata = m1.wdata;
      end else begin
        sel_req   = m0.req;
        sel_wr    = m0.wr;
        sel_size  = m0.size;
        sel_addr  = m0.addr;
        sel_wdata = m0.wdata;
      end
    end
  end

  // a full owner FIFO stalls new requests so no response can ever go unrouted
  assign s_req_w = sel_req & ~fifo_full;
  assign accept  = s_req_w & s.addr_ok;
  assign pop     = s.data_ok & ~fifo_empty;

  assign s.req   = s_req_w;
  assign s.wr    = sel_wr;
  assign s.size  = sel_size;
  assign s.addr  = sel_addr;
  assign s.wdata = sel_wdata;

  assign m0.addr_ok = accept & (gnt_own == OWN_M0);
  assign m1.addr_ok = accept & (gnt_own == OWN_M1);
  assign m0.data_ok = pop & (fifo_head == OWN_M0);
  assign m1.data_ok = pop & (fifo_head == OWN_M1);
  assign m0.rdata   = s.rdata;
  assign m1.rdata   = s.rdata;

  assign lock_d     = s_req_w & ~s.addr_ok;
  assign lock_own_d = gnt_own;
  assign resp_err_d = resp_err_q | (s.data_ok & fifo_empty);
  assign resp_err   = resp_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q     <= 1'b0;
      lock_own_q <= OWN_M0;
      resp_err_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_own_q <= lock_own_d;
      resp_err_q <= resp_err_d;
    end
  end

  owner_fifo #(.DEPTH(DEPTH)) u_owner_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .din_i   (gnt_own),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_bridge_2_1.sv
// Directed plus random checks of bridge_2_1 against a queue-based ownership model.
module tb_bridge_2_1;
  import bridge_pkg::*;

  localparam int D = bridge_pkg::DEPTH;

  logic clk = 1'b0;
  logic rst;
  logic resp_err;

  always #5 clk = ~clk;

  bridge_2_1_if m0_if ();
  bridge_2_1_if m1_if ();
  bridge_2_1_if s_if ();

  bridge_2_1 #(.DEPTH(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .m0       (m0_if),
    .m1       (m1_if),
    .s        (s_if),
    .resp_err (resp_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit rr;
  int own_q[$];
  int held = -1;
  int last = 0;
  bit err_m = 1'b0;
  bit acc0, acc1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_m(input int id, input bit rq, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    if (id == 0) begin
      m0_if.req = rq; m0_if.wr = w; m0_if.size = sz; m0_if.addr = a; m0_if.wdata = wd;
    end else begin
      m1_if.req = rq; m1_if.wr = w; m1_if.size = sz; m1_if.addr = a; m1_if.wdata = wd;
    end
  endtask

  task automatic set_s(input bit aok, input bit dok, input logic [31:0] rd);
    s_if.addr_ok = aok; s_if.data_ok = dok; s_if.rdata = rd;
  endtask

  task automatic idle();
    set_m(0, 0, 0, 2'd0, 32'h0, 32'h0);
    set_m(1, 0, 0, 2'd0, 32'h0, 32'h0);
    set_s(0, 0, 32'h0);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model.
  task automatic cyc();
    int g;
    bit full, sreq, acc, dok;
    logic [31:0] e_addr, e_wdata;
    logic [1:0]  e_size;
    logic        e_wr;
    @(negedge clk);
    full = (own_q.size() == D);
    if (held >= 0)                     g = held;
    else if (m0_if.req && m1_if.req)   g = rr ? ((last == 0) ? 1 : 0) : 1;
    else if (m1_if.req)                g = 1;
    else if (m0_if.req)                g = 0;
    else                               g = -1;
    sreq = (g >= 0) && !full;
    e_addr = 32'h0; e_wdata = 32'h0; e_size = 2'd0; e_wr = 1'b0;
    if (g == 1) begin
      e_addr = m1_if.addr; e_wdata = m1_if.wdata; e_size = m1_if.size; e_wr = m1_if.wr;
    end else if (g == 0) begin
      e_addr = m0_if.addr; e_wdata = m0_if.wdata; e_size = m0_if.size; e_wr = m0_if.wr;
    end
    acc = sreq && s_if.addr_ok;
    dok = s_if.data_ok && (own_q.size() > 0);
    chk("s_req",   32'(s_if.req),  32'(sreq));
    chk("s_addr",  s_if.addr,      e_addr);
    chk("s_wdata", s_if.wdata,     e_wdata);
    chk("s_size",  32'(s_if.size), 32'(e_size));
    chk("s_wr",    32'(s_if.wr),   32'(e_wr));
    chk("m0_addr_ok", 32'(m0_if.addr_ok), 32'(acc && g == 0));
    chk("m1_addr_ok", 32'(m1_if.addr_ok), 32'(acc && g == 1));
    chk("m0_data_ok", 32'(m0_if.data_ok), 32'(dok && own_q[0] == 0));
    chk("m1_data_ok", 32'(m1_if.data_ok), 32'(dok && own_q[0] == 1));
    chk("m0_rdata", m0_if.rdata, s_if.rdata);
    chk("m1_rdata", m1_if.rdata, s_if.rdata);
    chk("resp_err", 32'(resp_err), 32'(err_m));
    acc0 = acc && g == 0;
    acc1 = acc && g == 1;
    if (!rst) begin
      if (dok) void'(own_q.pop_front());
      else if (s_if.data_ok) err_m = 1'b1;
      if (acc) begin
        own_q.push_back(g);
        last = g;
      end
      held = (sreq && !s_if.addr_ok) ? g : -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit dok_during);
    rst = 1'b1;
    own_q.delete();
    held = -1; last = 0; err_m = 1'b0;
    idle();
    s_if.data_ok = dok_during;
    cyc();
    s_if.data_ok = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    bit p0, p1;
    logic [31:0] a0, a1, w0, w1;
    logic [1:0]  z0, z1;
    bit wr0, wr1;
`ifdef BRIDGE_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    rst = 1'b1;
    idle();
    #1;
    do_reset(1'b0);

    // lone m0 read with 2-cycle response
    set_m(0, 1, 0, SIZE_WORD, 32'hBFC00000, 32'h0);
    set_s(1, 0, 32'h0);
    cyc();
    set_m(0, 0, 0, SIZE_WORD, 32'h0, 32'h0);
    set_s(0, 0, 32'h0);
    cyc();
    set_s(0, 1, 32'h12345678);
    cyc();
    set_s(0, 0, 32'h0);
    cyc();

    // contention with slave stalling for three cycles
    set_m(0, 1, 0, SIZE_HALF, 32'h0000_1000, 32'h0);
    set_m(1, 1, 1, SIZE_WORD, 32'h8000_2000, 32'hCAFE_F00D);
    set_s(0, 0, 32'h0);
    repeat (3) cyc();
    set_s(1, 0, 32'h0);
    cyc();
    set_m(1, 1, 0, SIZE_BYTE, 32'h8000_2004, 32'h0);
    cyc();
    if (acc0) set_m(0, 0, 0, 2'd0, 32'h0, 32'h0);
    if (acc1) set_m(1, 0, 0, 2'd0, 32'h0, 32'h0);
    cyc();
    idle();
    repeat (3) begin
      set_s(0, 1, $urandom);
      cyc();
    end
    idle();
    cyc();

    // interleaved m1, m0, m1 with in-order responses
    set_s(1, 0, 32'h0);
    set_m(1, 1, 0, SIZE_WORD, 32'h10, 32'h0); cyc(); set_m(1, 0, 0, 2'd0, 32'h0, 32'h0);
    set_m(0, 1, 1, SIZE_WORD, 32'h20, 32'h5A5A_5A5A); cyc(); set_m(0, 0, 0, 2'd0, 32'h0, 32'h0);
    set_m(1, 1, 0, SIZE_HALF, 32'h30, 32'h0); cyc(); set_m(1, 0, 0, 2'd0, 32'h0, 32'h0);
    repeat (3) begin
      set_s(0, 1, $urandom);
      cyc();
    end
    idle();
    cyc();

    // fill to DEPTH, then stall, pop, and accept around the full boundary
    set_s(1, 0, 32'h0);
    for (int i = 0; i < D; i++) begin
      set_m(0, 1, 0, SIZE_WORD, 32'h100 + 32'(i * 4), 32'h0);
      cyc();
    end
    set_m(0, 1, 0, SIZE_WORD, 32'h200, 32'h0);
    cyc();
    set_s(1, 1, 32'hDEAD_BEEF);
    cyc();
    set_s(1, 0, 32'h0);
    cyc();
    set_m(0, 1, 0, SIZE_WORD, 32'h204, 32'h0);
    set_s(1, 0, 32'h0);
    cyc();
    set_s(1, 1, 32'h0BAD_F00D);
    cyc();
    set_s(1, 0, 32'h0);
    set_m(0, 1, 0, SIZE_WORD, 32'h208, 32'h0);
    cyc();
    cyc();
    idle();
    repeat (D) begin
      set_s(0, 1, $urandom);
      cyc();
    end
    idle();
    cyc();

    // stray response sets sticky error
    do_reset(1'b0);
    set_s(0, 1, 32'h7777_7777);
    cyc();
    idle();
    repeat (3) cyc();
    do_reset(1'b0);
    cyc();

    // reset with two outstanding discards ownership
    set_s(1, 0, 32'h0);
    set_m(0, 1, 0, SIZE_WORD, 32'h40, 32'h0); cyc(); set_m(0, 0, 0, 2'd0, 32'h0, 32'h0);
    set_m(1, 1, 0, SIZE_WORD, 32'h44, 32'h0); cyc();
    do_reset(1'b1);
    set_s(0, 1, 32'h1);
    cyc();
    idle();
    cyc();
    do_reset(1'b0);

    // random traffic
    p0 = 0; p1 = 0;
    a0 = 0; a1 = 0; w0 = 0; w1 = 0; z0 = 0; z1 = 0; wr0 = 0; wr1 = 0;
    for (int k = 0; k < 400; k++) begin
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; a0 = $urandom; w0 = $urandom; z0 = 2'($urandom_range(0, 2)); wr0 = 1'($urandom);
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; a1 = $urandom; w1 = $urandom; z1 = 2'($urandom_range(0, 2)); wr1 = 1'($urandom);
      end
      set_m(0, p0, wr0, z0, p0 ? a0 : 32'h0, p0 ? w0 : 32'h0);
      set_m(1, p1, wr1, z1, p1 ? a1 : 32'h0, p1 ? w1 : 32'h0);
      set_s($urandom_range(0, 2) != 0,
            (own_q.size() > 0) && ($urandom_range(0, 2) == 0),
            $urandom);
      cyc();
      if (acc0) p0 = 0;
      if (acc1) p1 = 0;
    end
    idle();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
